// File: rtl/fc_pkg.sv
// Shared definitions for the measurement-core controller: register map, STATUS bit layout, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fc_pkg;

  // Register map (6-bit bus address)
  localparam logic [5:0] ADDR_STATUS  = 6'h10;
  localparam logic [5:0] ADDR_AVG     = 6'h11;
  localparam logic [5:0] ADDR_BUF0    = 6'h12;  // BUF[k] at ADDR_BUF0 + k
  localparam logic [5:0] ADDR_CH_SEL  = 6'h21;
  localparam logic [5:0] ADDR_SAMPLES = 6'h22;
  localparam logic [5:0] ADDR_CTRL    = 6'h23;
  localparam logic [5:0] ADDR_TIMEOUT = 6'h24;
  localparam logic [5:0] ADDR_ABORT   = 6'h2E;
  localparam logic [5:0] ADDR_START   = 6'h2F;

  // STATUS bit positions; bits 1..4 are sticky, write-1-to-clear
  localparam int STS_BUSY  = 0;
  localparam int STS_DONE  = 1;
  localparam int STS_TMO   = 2;
  localparam int STS_BADCH = 3;
  localparam int STS_OVR   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } fc_state_t;

endpackage

// File: rtl/fc_regbank.sv
// Bus register bank: config registers, sticky STATUS flags, command strobes and readback mux.
// Latency: writes land on the strobe edge; bus_rdata is valid one cycle after bus_rd and holds otherwise.
// Backpressure: none; every bus access is accepted in the cycle it is presented.
//
// Ports: Clock/Reset; bus_addr/bus_wdata/bus_wr/bus_rd/bus_rdata register bus;
//        ch_sel/samples/irq_en/continuous/tmo_val config out; start_wr/abort_wr/avg_rd strobes out;
//        flag_set in / flags out (STATUS bits 4:1); busy, avg_res, buf_res readback inputs.
module fc_regbank
  import fc_pkg::*;
#(
  parameter int DATA_W    = 10,
  parameter int BUF_DEPTH = 8,
  parameter int TMO_W     = 16
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [5:0]                    bus_addr,
  input  logic [15:0]                   bus_wdata,
  input  logic                          bus_wr,
  input  logic                          bus_rd,
  output logic [15:0]                   bus_rdata,
  output logic [15:0]                   ch_sel,
  output logic [15:0]                   samples,
  output logic                          irq_en,
  output logic                          continuous,
  output logic [TMO_W-1:0]              tmo_val,
  output logic                          start_wr,
  output logic                          abort_wr,
  output logic                          avg_rd,
  input  logic [4:1]                    flag_set,
  output logic [4:1]                    flags,
  input  logic                          busy,
  input  logic [DATA_W-1:0]             avg_res,
  input  logic [BUF_DEPTH*DATA_W-1:0]   buf_res
);

  logic        sts_wr;
  logic [15:0] rd_mux;

  assign start_wr = bus_wr && (bus_addr == ADDR_START);
  assign abort_wr = bus_wr && (bus_addr == ADDR_ABORT);
  assign sts_wr   = bus_wr && (bus_addr == ADDR_STATUS);
  assign avg_rd   = bus_rd && (bus_addr == ADDR_AVG);

  always_comb begin
    rd_mux = '0;
    case (bus_addr)
      ADDR_STATUS:  rd_mux = {11'd0, flags, busy};
      ADDR_AVG:     rd_mux[DATA_W-1:0] = avg_res;
      ADDR_CH_SEL:  rd_mux = ch_sel;
      ADDR_SAMPLES: rd_mux = samples;
      ADDR_CTRL:    rd_mux = {14'd0, continuous, irq_en};
      ADDR_TIMEOUT: rd_mux[TMO_W-1:0] = tmo_val;
      default:      ;
    endcase
    for (int k = 0; k < BUF_DEPTH; k++) begin
      if (bus_addr == ADDR_BUF0 + 6'(k)) rd_mux[DATA_W-1:0] = buf_res[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ch_sel     <= '0;
      samples    <= '0;
      irq_en     <= 1'b0;
      continuous <= 1'b0;
      tmo_val    <= '0;
      flags      <= '0;
      bus_rdata  <= '0;
    end else begin
      if (bus_wr) begin
        case (bus_addr)
          ADDR_CH_SEL:  ch_sel  <= bus_wdata;
          ADDR_SAMPLES: samples <= bus_wdata;
          ADDR_CTRL: begin
            irq_en     <= bus_wdata[0];
            continuous <= bus_wdata[1];
          end
          ADDR_TIMEOUT: tmo_val <= bus_wdata[TMO_W-1:0];
          default:      ;
        endcase
      end
      // A hardware set in the same cycle as a W1C clear keeps the bit set.
      flags <= flag_set | (flags & ~({4{sts_wr}} & bus_wdata[4:1]));
      if (bus_rd) bus_rdata <= rd_mux;
    end
  end

endmodule

// File: rtl/fc_control_multi.sv
// Measurement-core controller: arms the core on START, waits for done_flag or timeout, captures results.
// Latency: START write -> ARM next cycle (1 cycle, core held in reset) -> RUN; done_flag edge -> capture.
// Backpressure: none; bus commands are accepted immediately, START outside IDLE is dropped.
//
// Ports: Clock/Reset; bus_* register bus; irq_out level interrupt; busy measurement in progress;
//        select_input/samples_required/enable/core_nreset drive the core; done_flag/average/buff come back.
module fc_control_multi
  import fc_pkg::*;
#(
  parameter int N_CH      = 32,
  parameter int DATA_W    = 10,
  parameter int BUF_DEPTH = 8,
  parameter int TMO_W     = 16
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [5:0]                    bus_addr,
  input  logic [15:0]                   bus_wdata,
  input  logic                          bus_wr,
  input  logic                          bus_rd,
  output logic [15:0]                   bus_rdata,
  output logic                          irq_out,
  output logic                          busy,
  output logic [$clog2(N_CH)-1:0]       select_input,
  output logic [15:0]                   samples_required,
  output logic                          enable,
  output logic                          core_nreset,
  input  logic                          done_flag,
  input  logic [DATA_W-1:0]             average,
  input  logic [BUF_DEPTH*DATA_W-1:0]   buff
);

  localparam int SEL_W = $clog2(N_CH);

  fc_state_t                   state, state_n;
  logic [15:0]                 ch_sel, samples;
  logic                        irq_en, continuous;
  logic [TMO_W-1:0]            tmo_val, tmo_cnt;
  logic                        start_wr, abort_wr, avg_rd;
  logic [4:1]                  flag_set, flags;
  logic [DATA_W-1:0]           avg_res;
  logic [BUF_DEPTH*DATA_W-1:0] buf_res;
  logic                        result_valid;
  logic                        capture;
  logic                        ch_ok;

  assign ch_ok = ch_sel < 16'(N_CH);

  fc_regbank #(
    .DATA_W    (DATA_W),
    .BUF_DEPTH (BUF_DEPTH),
    .TMO_W     (TMO_W)
  ) u_regbank (
    .Clock      (Clock),
    .Reset      (Reset),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_wr     (bus_wr),
    .bus_rd     (bus_rd),
    .bus_rdata  (bus_rdata),
    .ch_sel     (ch_sel),
    .samples    (samples),
    .irq_en     (irq_en),
    .continuous (continuous),
    .tmo_val    (tmo_val),
    .start_wr   (start_wr),
    .abort_wr   (abort_wr),
    .avg_rd     (avg_rd),
    .flag_set   (flag_set),
    .flags      (flags),
    .busy       (busy),
    .avg_res    (avg_res),
    .buf_res    (buf_res)
  );

  // Next state and flag-set pulses. ABORT takes priority everywhere, so a
  // coincident done_flag neither captures nor touches any flag.
  always_comb begin
    state_n  = state;
    capture  = 1'b0;
    flag_set = '0;
    case (state)
      IDLE: begin
        if (!abort_wr && start_wr) begin
          if (ch_ok) state_n = ARM;
          else       flag_set[STS_BADCH] = 1'b1;
        end
      end
      ARM: state_n = abort_wr ? IDLE : RUN;
      RUN: begin
        if (abort_wr) begin
          state_n = IDLE;
        end else if (done_flag) begin
          state_n = DONE;
          capture = 1'b1;
        end else if ((tmo_val != '0) && (tmo_cnt == TMO_W'(1))) begin
          state_n = IDLE;
          flag_set[STS_TMO] = 1'b1;
        end
      end
      DONE: begin
        if (abort_wr)        state_n = IDLE;
        else if (continuous) state_n = ARM;
        else                 state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    flag_set[STS_DONE] = capture;
    flag_set[STS_OVR]  = capture & result_valid;
  end

  // Core-facing outputs are registered from state_n so they line up with the
  // state they belong to and reset cleanly (core_nreset low while Reset is high).
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state            <= IDLE;
      tmo_cnt          <= '0;
      select_input     <= '0;
      samples_required <= '0;
      enable           <= 1'b0;
      busy             <= 1'b0;
      core_nreset      <= 1'b0;
      avg_res          <= '0;
      buf_res          <= '0;
      result_valid     <= 1'b0;
      irq_out          <= 1'b0;
    end else begin
      state       <= state_n;
      enable      <= (state_n == RUN);
      busy        <= (state_n != IDLE);
      core_nreset <= (state_n != ARM);

      // Channel and sample count only reach the core when a measurement is armed.
      if (state_n == ARM) begin
        tmo_cnt          <= tmo_val;
        select_input     <= ch_sel[SEL_W-1:0];
        samples_required <= samples;
      end else if ((state == RUN) && (tmo_cnt != '0)) begin
        tmo_cnt <= tmo_cnt - TMO_W'(1);
      end

      if (capture) begin
        avg_res      <= average;
        buf_res      <= buff;
        result_valid <= 1'b1;
      end else if (avg_rd) begin
        result_valid <= 1'b0;
      end

      irq_out <= irq_en & (|flags);
    end
  end

endmodule

// File: tb/tb_fc_control_multi.sv
// Self-checking bench for fc_control_multi: register table plus directed measurement sequences.
module tb_fc_control_multi;

  localparam int N_CH      = 32;
  localparam int DATA_W    = 10;
  localparam int BUF_DEPTH = 8;
  localparam int TMO_W     = 16;

  localparam logic [5:0] A_STATUS  = 6'h10;
  localparam logic [5:0] A_AVG     = 6'h11;
  localparam logic [5:0] A_BUF0    = 6'h12;
  localparam logic [5:0] A_CH_SEL  = 6'h21;
  localparam logic [5:0] A_SAMPLES = 6'h22;
  localparam logic [5:0] A_CTRL    = 6'h23;
  localparam logic [5:0] A_TIMEOUT = 6'h24;
  localparam logic [5:0] A_ABORT   = 6'h2E;
  localparam logic [5:0] A_START   = 6'h2F;

  logic                        Clock = 1'b0;
  logic                        Reset = 1'b1;
  logic [5:0]                  bus_addr = '0;
  logic [15:0]                 bus_wdata = '0;
  logic                        bus_wr = 1'b0;
  logic                        bus_rd = 1'b0;
  logic [15:0]                 bus_rdata;
  logic                        irq_out, busy, enable, core_nreset;
  logic [$clog2(N_CH)-1:0]     select_input;
  logic [15:0]                 samples_required;
  logic                        done_flag = 1'b0;
  logic [DATA_W-1:0]           average = '0;
  logic [BUF_DEPTH*DATA_W-1:0] buff = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clock = ~Clock;

  fc_control_multi #(
    .N_CH(N_CH), .DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH), .TMO_W(TMO_W)
  ) dut (
    .Clock            (Clock),
    .Reset            (Reset),
    .bus_addr         (bus_addr),
    .bus_wdata        (bus_wdata),
    .bus_wr           (bus_wr),
    .bus_rd           (bus_rd),
    .bus_rdata        (bus_rdata),
    .irq_out          (irq_out),
    .busy             (busy),
    .select_input     (select_input),
    .samples_required (samples_required),
    .enable           (enable),
    .core_nreset      (core_nreset),
    .done_flag        (done_flag),
    .average          (average),
    .buff             (buff)
  );

  typedef struct {
    logic [5:0]  addr;
    logic        wr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [15:0] d);
    @(negedge Clock);
    bus_addr  = a;
    bus_wdata = d;
    bus_wr    = 1'b1;
    @(negedge Clock);
    bus_wr    = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [5:0] a, input logic [15:0] exp);
    @(negedge Clock);
    bus_addr = a;
    bus_rd   = 1'b1;
    @(negedge Clock);
    bus_rd   = 1'b0;
    check(name, bus_rdata, exp);
  endtask

  // One-cycle done_flag pulse; average/buff are scrubbed afterwards so only a
  // real capture on the pulse edge can leave the values in the result registers.
  task automatic pulse_done(input logic [DATA_W-1:0] avg, input logic [DATA_W-1:0] base);
    @(negedge Clock);
    done_flag = 1'b1;
    average   = avg;
    for (int k = 0; k < BUF_DEPTH; k++) buff[k*DATA_W +: DATA_W] = base + DATA_W'(k);
    @(negedge Clock);
    done_flag = 1'b0;
    average   = '0;
    buff      = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_en;

    vecs[0]  = '{A_CH_SEL,  1'b1, 16'd5,     16'd5};
    vecs[1]  = '{A_CH_SEL,  1'b1, 16'hFFFF,  16'hFFFF};
    vecs[2]  = '{A_SAMPLES, 1'b1, 16'd100,   16'd100};
    vecs[3]  = '{A_CTRL,    1'b1, 16'hFFFF,  16'h0003};
    vecs[4]  = '{A_TIMEOUT, 1'b1, 16'hBEEF,  16'hBEEF};
    vecs[5]  = '{A_AVG,     1'b1, 16'h0155,  16'h0000};
    vecs[6]  = '{A_STATUS,  1'b1, 16'h001F,  16'h0000};
    vecs[7]  = '{A_START,   1'b0, 16'h0000,  16'h0000};
    vecs[8]  = '{6'h3A,     1'b1, 16'h1234,  16'h0000};
    vecs[9]  = '{A_BUF0,    1'b0, 16'h0000,  16'h0000};
    vecs[10] = '{A_CTRL,    1'b1, 16'h0000,  16'h0000};
    vecs[11] = '{A_TIMEOUT, 1'b1, 16'h0000,  16'h0000};

    // Reset state
    #1;
    check("rst_enable", enable, 0);
    check("rst_busy", busy, 0);
    check("rst_core_nreset", core_nreset, 0);
    check("rst_irq", irq_out, 0);
    check("rst_rdata", bus_rdata, 0);
    check("rst_select", select_input, 0);
    check("rst_samples", samples_required, 0);
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    #1 check("nreset_before_edge", core_nreset, 0);
    @(negedge Clock);
    check("nreset_after_edge", core_nreset, 1);

    // Register table
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
      read_check($sformatf("reg_vec%0d", i), vecs[i].addr, vecs[i].exp);
    end
    read_check("rd_samples", A_SAMPLES, 16'd100);
    @(negedge Clock);
    bus_addr = A_CH_SEL;
    repeat (2) @(negedge Clock);
    check("rdata_hold", bus_rdata, 16'd100);

    // Basic measurement
    bus_write(A_CH_SEL, 16'd5);
    bus_write(A_SAMPLES, 16'd100);
    bus_write(A_START, 16'd1);
    check("arm_nreset", core_nreset, 0);
    check("arm_busy", busy, 1);
    check("arm_enable", enable, 0);
    check("arm_select", select_input, 5);
    check("arm_samples", samples_required, 100);
    @(negedge Clock);
    check("run_enable", enable, 1);
    check("run_nreset", core_nreset, 1);
    bus_write(A_CH_SEL, 16'd7);
    check("select_held_busy", select_input, 5);
    repeat (16) @(negedge Clock);
    check("run_still_enabled", enable, 1);
    pulse_done(10'h2A5, 10'h100);
    check("en_low_after_done", enable, 0);
    @(negedge Clock);
    check("idle_after_done", busy, 0);
    read_check("status_done", A_STATUS, 16'h0002);
    check("irq_disabled", irq_out, 0);
    read_check("avg", A_AVG, 16'h02A5);
    for (int k = 0; k < BUF_DEPTH; k++)
      read_check($sformatf("buf1_%0d", k), A_BUF0 + 6'(k), 16'h0100 + 16'(k));
    read_check("ch_sel_updated", A_CH_SEL, 16'd7);
    pulse_done(10'h3FF, 10'h000);
    read_check("avg_ignore_idle_done", A_AVG, 16'h02A5);
    read_check("status_ignore_idle_done", A_STATUS, 16'h0002);
    bus_write(A_STATUS, 16'h0002);
    read_check("status_w1c", A_STATUS, 16'h0000);

    // Timeout
    bus_write(A_CTRL, 16'h0001);
    bus_write(A_TIMEOUT, 16'd10);
    bus_write(A_START, 16'd1);
    repeat (10) @(negedge Clock);
    check("tmo_busy_last_run", busy, 1);
    @(negedge Clock);
    check("tmo_idle_busy", busy, 0);
    check("tmo_idle_enable", enable, 0);
    @(negedge Clock);
    check("tmo_irq", irq_out, 1);
    read_check("status_tmo", A_STATUS, 16'h0004);
    bus_write(A_STATUS, 16'h0004);
    @(negedge Clock);
    check("irq_cleared", irq_out, 0);
    bus_write(A_TIMEOUT, 16'd0);

    // Bad channel, then the highest legal channel
    bus_write(A_CH_SEL, 16'd40);
    bus_write(A_START, 16'd1);
    saw_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      if (enable) saw_en = 1'b1;
    end
    check("badch_no_enable", saw_en, 0);
    check("badch_irq", irq_out, 1);
    read_check("status_badch", A_STATUS, 16'h0008);
    bus_write(A_CH_SEL, 16'd31);
    bus_write(A_START, 16'd1);
    check("ch31_busy", busy, 1);
    check("ch31_select", select_input, 31);
    bus_write(A_ABORT, 16'd1);
    check("abort_arm_busy", busy, 0);
    bus_write(A_STATUS, 16'h001F);
    read_check("status_clear_all", A_STATUS, 16'h0000);

    // Continuous mode, two captures without an AVG read
    bus_write(A_CTRL, 16'h0002);
    bus_write(A_CH_SEL, 16'd3);
    bus_write(A_START, 16'd1);
    repeat (4) @(negedge Clock);
    pulse_done(10'h111, 10'h050);
    @(negedge Clock);
    check("cont_rearm_nreset", core_nreset, 0);
    @(negedge Clock);
    check("cont_rerun_enable", enable, 1);
    // Second capture coincides with a W1C of the done bit: the set must win.
    @(negedge Clock);
    done_flag = 1'b1;
    average   = 10'h222;
    for (int k = 0; k < BUF_DEPTH; k++) buff[k*DATA_W +: DATA_W] = 10'h0A0 + DATA_W'(k);
    bus_addr  = A_STATUS;
    bus_wdata = 16'h0002;
    bus_wr    = 1'b1;
    @(negedge Clock);
    done_flag = 1'b0;
    bus_wr    = 1'b0;
    average   = '0;
    buff      = '0;
    bus_write(A_ABORT, 16'd1);
    check("cont_abort_enable", enable, 0);
    check("cont_abort_busy", busy, 0);
    read_check("status_overrun", A_STATUS, 16'h0012);
    for (int k = 0; k < BUF_DEPTH; k++)
      read_check($sformatf("buf2_%0d", k), A_BUF0 + 6'(k), 16'h00A0 + 16'(k));
    read_check("avg2", A_AVG, 16'h0222);

    // ABORT coincident with done_flag
    bus_write(A_STATUS, 16'h001F);
    bus_write(A_CTRL, 16'h0000);
    bus_write(A_START, 16'd1);
    repeat (3) @(negedge Clock);
    check("abort_pre_enable", enable, 1);
    bus_addr  = A_ABORT;
    bus_wr    = 1'b1;
    done_flag = 1'b1;
    average   = 10'h3C3;
    buff      = '1;
    @(negedge Clock);
    bus_wr    = 1'b0;
    done_flag = 1'b0;
    check("abort_done_enable", enable, 0);
    check("abort_done_busy", busy, 0);
    read_check("abort_done_status", A_STATUS, 16'h0000);
    read_check("abort_done_avg", A_AVG, 16'h0222);
    read_check("abort_done_buf0", A_BUF0, 16'h00A0);

    // Reset asserted mid-RUN
    bus_write(A_CH_SEL, 16'd9);
    bus_write(A_SAMPLES, 16'd55);
    bus_write(A_CTRL, 16'h0001);
    bus_write(A_START, 16'd1);
    @(negedge Clock);
    check("pre_reset_enable", enable, 1);
    #2 Reset = 1'b1;
    #1;
    check("midrst_enable", enable, 0);
    check("midrst_busy", busy, 0);
    check("midrst_nreset", core_nreset, 0);
    check("midrst_select", select_input, 0);
    check("midrst_samples", samples_required, 0);
    check("midrst_irq", irq_out, 0);
    check("midrst_rdata", bus_rdata, 0);
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    check("post_rst_nreset", core_nreset, 1);
    read_check("post_rst_avg", A_AVG, 16'h0000);
    read_check("post_rst_ch_sel", A_CH_SEL, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_control_multi.md
FC_CONTROL_MULTI -- requirements
Module: fc_control_multi

Interface
REQ-001 SHALL have parameter N_CH, default 32, number of selectable measurement inputs (2..64).
REQ-002 SHALL have parameter DATA_W, default 10, width of average and buffer samples (1..16).
REQ-003 SHALL have parameter BUF_DEPTH, default 8, number of buffer samples captured (1..14).
REQ-004 SHALL have parameter TMO_W, default 16, width of the timeout counter.
REQ-005 SHALL have ports: Clock  in  1  sole clock, rising edge; Reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports: bus_addr  in  6  register address; bus_wdata  in  16  write data; bus_wr  in  1  write strobe; bus_rd  in  1  read strobe; bus_rdata  out  16  read data.
REQ-007 SHALL have ports: irq_out  out  1  level interrupt; busy  out  1  measurement in progress.
REQ-008 SHALL have ports: select_input  out  $clog2(N_CH)  channel select; samples_required  out  16  sample count; enable  out  1  core run; core_nreset  out  1  active-low core reset.
REQ-009 SHALL have ports: done_flag  in  1  core done pulse; average  in  DATA_W  core average; buff  in  BUF_DEPTH*DATA_W  packed samples, sample k at bits [k*DATA_W +: DATA_W].

Function
REQ-010 SHALL decode: 0x21 CH_SEL RW; 0x22 SAMPLES RW; 0x23 CTRL RW (bit0 irq_en, bit1 continuous); 0x24 TIMEOUT RW (TMO_W bits, 0 = disabled); 0x2E ABORT WO; 0x2F START WO; 0x10 STATUS; 0x11 AVG RO; 0x12+k BUF[k] RO.
REQ-011 SHALL update RW registers on the rising edge where bus_wr is high; writes to unmapped or RO addresses (except STATUS) SHALL be ignored.
REQ-012 SHALL drive bus_rdata one cycle after bus_rd, zero-extended; unmapped addresses SHALL return 0; bus_rdata SHALL hold its value when bus_rd is low.
REQ-013 STATUS bits SHALL be: 0 busy, 1 done, 2 timeout, 3 bad_ch, 4 overrun; bits 1-4 sticky, cleared by writing 1 to them (W1C).
REQ-014 FSM states SHALL be IDLE, ARM, RUN, DONE.
REQ-015 IDLE: START write moves to ARM if CH_SEL < N_CH; otherwise stays IDLE and sets bad_ch.
REQ-016 ARM: lasts exactly one cycle with core_nreset=0, timeout counter loaded with TIMEOUT, then RUN.
REQ-017 RUN: enable=1, busy=1; done_flag moves to DONE; counter reaching 1 with TIMEOUT≠0 and no done_flag moves to IDLE and sets timeout.
REQ-018 DONE: lasts one cycle; average and buff are captured into result registers on the done_flag edge; done set; result_valid set.
REQ-019 DONE exit SHALL be ARM if continuous=1, else IDLE.
REQ-020 A capture while result_valid is already set SHALL set overrun and overwrite results; reading AVG SHALL clear result_valid.
REQ-021 ABORT in any state SHALL return to IDLE next cycle with enable=0, no capture, no flag change.
REQ-022 ABORT and done_flag in the same cycle: ABORT wins.
REQ-023 START while busy SHALL be ignored; CH_SEL/SAMPLES writes while busy SHALL update registers but select_input/samples_required SHALL change only on the next ARM.
REQ-024 irq_out SHALL equal irq_en AND (done OR timeout OR overrun OR bad_ch), registered.
REQ-025 core_nreset SHALL be 1 except in ARM and during Reset.
REQ-026 done_flag outside RUN SHALL be ignored.
REQ-027 A bus write and a hardware flag set to the same STATUS bit in one cycle: set wins.

Reset
REQ-028 Reset high SHALL asynchronously force IDLE; all registers, flags, results, bus_rdata, irq_out, enable, busy, select_input, samples_required to 0; core_nreset to 0.
REQ-029 After Reset falls, core_nreset SHALL go to 1 on the first Clock edge; reset mid-RUN SHALL discard the measurement.

Structure
REQ-030 Register address constants, STATUS bit indices and the FSM state enum SHALL live in package fc_pkg.
REQ-031 Bus decode/readback mux SHALL be one sub-module, fc_regbank; FSM, timeout counter and capture stay in the top.

Verification
REQ-032 CH_SEL=5, SAMPLES=100, START; done_flag after 20 cycles with average=0x2A5 -> STATUS=0x02, AVG read=0x02A5, enable low one cycle later.
REQ-033 TIMEOUT=10, START, no done_flag -> timeout bit set, FSM IDLE 11 cycles after ARM, irq_out=1 when irq_en=1.
REQ-034 CH_SEL=40 with N_CH=32, START -> bad_ch set, enable never asserted.
REQ-035 continuous=1, two done_flag pulses without AVG read -> overrun set, BUF[0..7] hold second capture.
REQ-036 ABORT coincident with done_flag -> IDLE, done=0, results unchanged; Reset asserted mid-RUN -> all outputs 0, core_nreset=0.
